msrv32_lsu_bus_ctrl: RTL and testbench
======================================

# msrv32_lsu_bus_ctrl

Data-memory bus controller downstream of the decode/execute pipeline register. It consumes the registered load/store controls (load size, load unsigned, effective address from the immediate adder, store data from rs2) and runs one request/acknowledge transaction per memory instruction on the data bus. It stalls the pipeline while the transaction is outstanding, then returns sign/zero-extended load data to the write-back mux. It also flags misaligned accesses and bus errors.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles in ACCESS without `dbus_ack_in` before a bus error is forced; legal range 2..255.
- clk_in  input  1  single clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- mem_rd_req_in  input  1  current instruction is a load.
- mem_wr_req_in  input  1  current instruction is a store.
- load_size_in  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  input  1  zero-extend (1) or sign-extend (0) loads.
- addr_in  input  32  effective address.
- store_data_in  input  32  store source (rs2).
- dbus_ack_in  input  1  slave completion strobe.
- dbus_err_in  input  1  slave error; qualified only by `dbus_ack_in`.
- dbus_rdata_in  input  32  read data; sampled when ack is high.
- dbus_addr_out  output  32  word-aligned bus address: {addr[31:2], 2'b00}.
- dbus_wdata_out  output  32  lane-replicated store data.
- dbus_wr_mask_out  output  4  byte-lane enables.
- dbus_rd_req_out  output  1  read request, level, held until ack.
- dbus_wr_req_out  output  1  write request, level, held until ack.
- stall_out  output  1  freeze upstream pipeline registers.
- load_data_out  output  32  formatted load result.
- load_valid_out  output  1  `load_data_out` valid, one-cycle pulse.
- misaligned_out  output  1  misaligned-access flag.
- bus_err_out  output  1  bus-error or timeout flag, one-cycle pulse.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A request is either request input high.
  - An aligned request registers the bus outputs, then moves to ACCESS.
  - If both requests are high, the store wins and the read is ignored.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - `misaligned_out` is high combinationally in IDLE.
  - No bus request is issued and the state stays IDLE.
- ACCESS:
  - The bus request is held and the timeout counter increments each cycle.
  - On `dbus_ack_in`: go to DONE. Read data is formatted and registered into `load_data_out` only for loads with `dbus_err_in`=0. `bus_err_out` is registered high if `dbus_err_in`=1.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE and register `bus_err_out` high.
- DONE:
  - Drops the requests.
  - `load_valid_out`=1 only for an error-free load.
  - Does not re-accept the still-present request.
  - Always returns to IDLE.
- Load formatting:
  - Byte: lane addr[1:0], bit 7 extended.
  - Half: lane addr[1], bit 15 extended.
  - Word: passed through.
- Store formatting:
  - Byte: wdata = {4{sd[7:0]}}, mask = 0001<<addr[1:0].
  - Half: wdata = {2{sd[15:0]}}, mask = 0011<<{addr[1],1'b0}.
  - Word: wdata = sd, mask = 1111.
  - Loads drive mask 0000.

## Timing
- Reset (async, low):
  - State goes to IDLE and the counter to 0.
  - Every output goes to 0, including `dbus_*_req_out`, `load_data_out` and the flags.
- A reset asserted mid-ACCESS drops the requests immediately. No ack is awaited.
- `stall_out` = (IDLE & aligned request) | ACCESS. It is low in DONE, so the pipeline advances at the end of DONE.
- Latency with a zero-wait slave (ack in the first ACCESS cycle): request seen in cycle 0, ACCESS in cycle 1, DONE with `load_valid_out` in cycle 2. Each wait state adds one cycle.
- Upstream inputs are held stable while `stall_out`=1.
- `dbus_ack_in` outside ACCESS is ignored.
- Ack arriving on the timeout cycle: the ack wins and no timeout error is raised.
- Back-to-back instructions: a new request can be accepted in the IDLE cycle that follows DONE.

## Test plan
- Word load at 0x100, slave acks after 3 wait states, rdata 0xDEADBEEF -> stall high for 5 cycles; `load_valid_out` pulses with 0xDEADBEEF; `dbus_addr_out`=0x100.
- Byte loads at 0x103 with rdata 0x80FF1234, signed then unsigned -> 0xFFFFFF80, then 0x00000080; half load at 0x102, signed -> 0xFFFF80FF.
- Byte store 0xAB at 0x201 -> wdata 0xABABABAB, mask 0010, `dbus_wr_req_out` held until ack; no `load_valid_out`.
- Word load at 0x102 -> `misaligned_out`=1 in the same cycle, no bus request, `stall_out`=0.
- Slave never acks, TIMEOUT_CYCLES=16 -> request dropped after 16 ACCESS cycles; `bus_err_out` pulses once; `load_valid_out` stays 0. Separately, ack with `dbus_err_in`=1 -> `bus_err_out` pulse, no valid.
- `reset_n_in` low in the second ACCESS cycle -> requests and all outputs go to 0 immediately; after release, a fresh load completes normally.

Source files
------------

// File: rtl/msrv32_lsu_bus_ctrl.sv
// Data-memory bus controller: one req/ack transaction per load/store, pipeline stall,
// load sign/zero extension, store lane replication, misalignment and bus-error flags.
module msrv32_lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        dbus_ack_in,
  input  logic        dbus_err_in,
  input  logic [31:0] dbus_rdata_in,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wr_mask_out,
  output logic        dbus_rd_req_out,
  output logic        dbus_wr_req_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]  mask_q, mask_d;
  logic        rd_q, rd_d, wr_q, wr_d, valid_q, valid_d, err_q, err_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d, off_q, off_d;

  logic        req, mis;
  logic [31:0] wfmt, lfmt;
  logic [3:0]  mfmt;
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    req = mem_rd_req_in | mem_wr_req_in;
    mis = ((load_size_in == 2'b01) & addr_in[0]) | (load_size_in[1] & (|addr_in[1:0]));
    case (load_size_in)
      2'b00: begin
        wfmt = {4{store_data_in[7:0]}};
        mfmt = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        wfmt = {2{store_data_in[15:0]}};
        mfmt = 4'b0011 << {addr_in[1], 1'b0};
      end
      default: begin
        wfmt = store_data_in;
        mfmt = 4'b1111;
      end
    endcase
    if (!mem_wr_req_in) mfmt = 4'b0000;
    // Offset/size/sign are latched at acceptance so formatting does not depend on upstream.
    lb = dbus_rdata_in[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? dbus_rdata_in[31:16] : dbus_rdata_in[15:0];
    case (size_q)
      2'b00:   lfmt = {{24{~uns_q & lb[7]}}, lb};
      2'b01:   lfmt = {{16{~uns_q & lh[15]}}, lh};
      default: lfmt = dbus_rdata_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    ldata_d = ldata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req && !mis) begin
        state_d = ACCESS;
        cnt_d   = 8'd0;
        addr_d  = {addr_in[31:2], 2'b00};
        wdata_d = wfmt;
        mask_d  = mfmt;
        wr_d    = mem_wr_req_in;
        rd_d    = ~mem_wr_req_in;
        size_d  = load_size_in;
        off_d   = addr_in[1:0];
        uns_d   = load_unsigned_in;
      end
      ACCESS: begin
        if (dbus_ack_in) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = dbus_err_in;
          if (rd_q && !dbus_err_in) begin
            ldata_d = lfmt;
            valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      ldata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      ldata_q <= ldata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Combinational flags are gated by reset so every output reads 0 while reset is held.
  assign stall_out        = reset_n_in & (((state_q == IDLE) & req & ~mis) | (state_q == ACCESS));
  assign misaligned_out   = reset_n_in & (state_q == IDLE) & req & mis;
  assign dbus_addr_out    = addr_q;
  assign dbus_wdata_out   = wdata_q;
  assign dbus_wr_mask_out = mask_q;
  assign dbus_rd_req_out  = rd_q;
  assign dbus_wr_req_out  = wr_q;
  assign load_data_out    = ldata_q;
  assign load_valid_out   = valid_q;
  assign bus_err_out      = err_q;
endmodule

// File: tb/tb_msrv32_lsu_bus_ctrl.sv
// Directed + random bench for msrv32_lsu_bus_ctrl against a transaction-level reference model.
module tb_msrv32_lsu_bus_ctrl;
  localparam int TO = 16;

  logic        clk_in = 1'b0, reset_n_in;
  logic        mem_rd_req_in, mem_wr_req_in, load_unsigned_in;
  logic [1:0]  load_size_in;
  logic [31:0] addr_in, store_data_in, dbus_rdata_in;
  logic        dbus_ack_in, dbus_err_in;
  logic [31:0] dbus_addr_out, dbus_wdata_out, load_data_out;
  logic [3:0]  dbus_wr_mask_out;
  logic        dbus_rd_req_out, dbus_wr_req_out, stall_out, load_valid_out, misaligned_out, bus_err_out;

  int npass = 0, ntot = 0;
  logic [31:0] got;

  msrv32_lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .mem_rd_req_in(mem_rd_req_in), .mem_wr_req_in(mem_wr_req_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .dbus_ack_in(dbus_ack_in), .dbus_err_in(dbus_err_in), .dbus_rdata_in(dbus_rdata_in),
    .dbus_addr_out(dbus_addr_out), .dbus_wdata_out(dbus_wdata_out),
    .dbus_wr_mask_out(dbus_wr_mask_out), .dbus_rd_req_out(dbus_rd_req_out),
    .dbus_wr_req_out(dbus_wr_req_out), .stall_out(stall_out),
    .load_data_out(load_data_out), .load_valid_out(load_valid_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [1:0] sz);
    if (sz == 2'b00) return (sd & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_mask(input logic wr, input logic [31:0] a, input logic [1:0] sz);
    if (!wr) return 0;
    if (sz == 2'b00) return 32'(1 << a[1:0]);
    if (sz == 2'b01) return 32'(3 << (2 * a[1]));
    return 15;
  endfunction

  task automatic clear_in();
    mem_rd_req_in = 0; mem_wr_req_in = 0; load_size_in = 0; load_unsigned_in = 0;
    addr_in = 0; store_data_in = 0; dbus_ack_in = 0; dbus_err_in = 0; dbus_rdata_in = 0;
  endtask

  // Starts and ends at posedge+1. Slave acks in ACCESS cycle number `waits` (0-based) unless never.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdata, input int waits, input logic err,
                     input logic never, output logic [31:0] ld);
    int total, stalls, reqs, nval, nerr, nmis;
    logic is_ld;
    is_ld = rd && !wr;
    total = never ? TO + 2 : waits + 3;
    stalls = 0; reqs = 0; nval = 0; nerr = 0; nmis = 0; ld = 'x;
    mem_rd_req_in = rd; mem_wr_req_in = wr; load_size_in = sz; load_unsigned_in = uns;
    addr_in = a; store_data_in = sd; dbus_rdata_in = rdata;
    for (int c = 0; c < total; c++) begin
      dbus_ack_in = !never && (c == waits + 1);
      dbus_err_in = dbus_ack_in && err;
      @(negedge clk_in);
      stalls += int'(stall_out);
      reqs   += int'(dbus_rd_req_out | dbus_wr_req_out);
      nmis   += int'(misaligned_out);
      nerr   += int'(bus_err_out);
      if (load_valid_out) begin nval++; ld = load_data_out; end
      if (c == 1) begin
        chk({tag, ".addr"}, dbus_addr_out, a & 32'hFFFFFFFC);
        chk({tag, ".mask"}, 32'(dbus_wr_mask_out), ref_mask(wr, a, sz));
        chk({tag, ".rdreq"}, 32'(dbus_rd_req_out), 32'(is_ld));
        chk({tag, ".wrreq"}, 32'(dbus_wr_req_out), 32'(wr));
        if (wr) chk({tag, ".wdata"}, dbus_wdata_out, ref_wdata(sd, sz));
      end
      @(posedge clk_in); #1;
    end
    clear_in();
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(total - 1));
    chk({tag, ".req_cycles"}, 32'(reqs), 32'(total - 2));
    chk({tag, ".misaligned"}, 32'(nmis), 0);
    chk({tag, ".valid_pulses"}, 32'(nval), 32'(is_ld && !err && !never));
    chk({tag, ".err_pulses"}, 32'(nerr), 32'(err || never));
    if (nval == 1) chk({tag, ".ldata"}, ld, ref_load(rdata, a, sz, uns));
  endtask

  initial begin
    logic rd, wr, uns, err;
    logic [1:0] sz;
    logic [31:0] a;
    clear_in();
    reset_n_in = 0;
    #2;
    chk("rst.rdreq", 32'(dbus_rd_req_out), 0);
    chk("rst.wrreq", 32'(dbus_wr_req_out), 0);
    chk("rst.ldata", load_data_out, 0);
    chk("rst.flags", 32'({stall_out, load_valid_out, misaligned_out, bus_err_out}), 0);
    chk("rst.bus", dbus_addr_out | dbus_wdata_out | 32'(dbus_wr_mask_out), 0);
    @(negedge clk_in); reset_n_in = 1;
    @(posedge clk_in); #1;

    txn("wload", 1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 3, 0, 0, got);
    chk("wload.lit", got, 32'hDEADBEEF);
    txn("bload_s", 1, 0, 2'b00, 0, 32'h103, 0, 32'h80FF1234, 0, 0, 0, got);
    chk("bload_s.lit", got, 32'hFFFFFF80);
    txn("bload_u", 1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF1234, 1, 0, 0, got);
    chk("bload_u.lit", got, 32'h00000080);
    txn("hload_s", 1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF1234, 0, 0, 0, got);
    chk("hload_s.lit", got, 32'hFFFF80FF);
    txn("bstore", 0, 1, 2'b00, 0, 32'h201, 32'h123456AB, 0, 2, 0, 0, got);
    chk("bstore.wdata_lit", dbus_wdata_out, 32'hABABABAB);
    chk("bstore.mask_lit", 32'(dbus_wr_mask_out), 32'h2);
    txn("both", 1, 1, 2'b01, 0, 32'h2, 32'hCAFE, 32'h5555, 1, 0, 0, got);

    // Misaligned word load: flagged in IDLE, never issued
    mem_rd_req_in = 1; load_size_in = 2'b10; addr_in = 32'h102;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      chk("mis.flag", 32'(misaligned_out), 1);
      chk("mis.stall", 32'(stall_out), 0);
      chk("mis.rdreq", 32'(dbus_rd_req_out), 0);
      @(posedge clk_in); #1;
    end
    clear_in();

    txn("timeout", 1, 0, 2'b10, 0, 32'h300, 0, 32'h1, 0, 0, 1, got);
    txn("ack_on_last", 1, 0, 2'b10, 0, 32'h304, 0, 32'h77, TO - 1, 0, 0, got);
    txn("err_ack", 1, 0, 2'b10, 0, 32'h308, 0, 32'h99, 1, 1, 0, got);

    // Stray ack while idle does nothing
    dbus_ack_in = 1; dbus_err_in = 1;
    @(negedge clk_in);
    @(posedge clk_in); #1;
    clear_in();
    @(negedge clk_in);
    chk("stray.flags", 32'({load_valid_out, bus_err_out, stall_out, dbus_rd_req_out}), 0);
    @(posedge clk_in); #1;

    // Reset in the second ACCESS cycle, request still presented
    mem_rd_req_in = 1; load_size_in = 2'b10; addr_in = 32'h400;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset_n_in = 0;
    #1;
    chk("midrst.rdreq", 32'(dbus_rd_req_out), 0);
    chk("midrst.stall", 32'(stall_out), 0);
    chk("midrst.ldata", load_data_out, 0);
    chk("midrst.addr", dbus_addr_out, 0);
    clear_in();
    @(negedge clk_in); reset_n_in = 1;
    @(posedge clk_in); #1;
    txn("postrst", 1, 0, 2'b00, 0, 32'h501, 0, 32'h0000F100, 0, 0, 0, got);
    chk("postrst.lit", got, 32'hFFFFFFF1);

    for (int i = 0; i < 25; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 7) == 0);
      a = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      txn("rand", rd, wr, sz, uns, a, $urandom, $urandom, int'($urandom_range(0, 4)), err, 0, got);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
